// File: rtl/dmem_lsu_pkg.sv
// Shared types for the data-memory load/store unit: op encodings, FSM states, default widths.
// Pure declarations, no logic, no latency, no backpressure.
package dmem_lsu_pkg;

    localparam int AW_DEF = 4;
    localparam int DW_DEF = 8;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'd0,
        OP_STORE = 3'd1,
        OP_ADD   = 3'd2,
        OP_AND   = 3'd3,
        OP_OR    = 3'd4,
        OP_XOR   = 3'd5,
        OP_SWAP  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } state_e;

    // Read-modify-write ops need both a read and a write cycle.
    function automatic logic is_rmw(op_e op);
        return (op != OP_LOAD) && (op != OP_STORE) && (op != OP_RSVD);
    endfunction

endpackage

// File: rtl/dmem_lsu_alu.sv
// Fetch-and-op combine of old memory value and operand; STORE and SWAP pass the operand through.
// Purely combinational, zero latency, no backpressure.
module dmem_lsu_alu
    import dmem_lsu_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  op_e          op,
    input  logic [DW-1:0] rdata,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] result
);

    always_comb begin
        result = wdata;
        case (op)
            OP_ADD:  result = rdata + wdata;
            OP_AND:  result = rdata & wdata;
            OP_OR:   result = rdata | wdata;
            OP_XOR:  result = rdata ^ wdata;
            OP_SWAP: result = wdata;
            default: result = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Single-outstanding load/store/fetch-and-op sequencer in front of a combinational-read data memory.
// Response 2 cycles after accept (3 for RMW); rsp_ready low parks the unit in RSP with memory idle.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          mem_e,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_di,
    input  logic [DW-1:0] mem_do
);

    state_e        state;
    state_e        state_nxt;
    op_e           op_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] di_q;
    logic [DW-1:0] alu_res;
    logic          accept;

    assign accept = req_valid && req_ready;

    dmem_lsu_alu #(.DW(DW)) u_alu (
        .op     (op_q),
        .rdata  (rdata_q),
        .wdata  (wdata_q),
        .result (alu_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_e     = 1'b0;
        mem_we    = 1'b0;
        mem_di    = di_q;
        case (state)
            IDLE: begin
                req_ready = !rst;
                if (req_valid && !rst) begin
                    state_nxt = (op_e'(req_op) == OP_STORE) ? WR : RD;
                end
            end
            RD: begin
                mem_e     = 1'b1;
                state_nxt = is_rmw(op_q) ? WR : RSP;
            end
            WR: begin
                // Write is suppressed in a reset cycle so an aborted RMW leaves memory untouched.
                mem_e     = 1'b1;
                mem_we    = !rst;
                mem_di    = alu_res;
                state_nxt = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= OP_LOAD;
            wdata_q  <= '0;
            rdata_q  <= '0;
            di_q     <= '0;
            mem_addr <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (accept) begin
                op_q     <= op_e'(req_op);
                wdata_q  <= req_wdata;
                mem_addr <= req_addr;
            end
            case (state)
                RD: begin
                    rdata_q <= mem_do;
                    if (!is_rmw(op_q)) begin
                        rsp_data <= mem_do;
                        rsp_err  <= (op_q == OP_RSVD);
                    end
                end
                WR: begin
                    // mem_di holds the last written value once the write cycle ends.
                    di_q     <= alu_res;
                    rsp_data <= (op_q == OP_STORE) ? wdata_q : rdata_q;
                    rsp_err  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit sitting directly upstream of the microcontroller's data memory. It accepts one memory request at a time from the execute stage over a valid/ready handshake and sequences the memory's enable, write-enable, address and data lines. It captures combinational read data and returns a response over a second valid/ready handshake. It also executes atomic read-modify-write ops (fetch-and-op), so the core never drives the memory directly.

## Interface
- `AW`, 4: address width; matches the data-memory address port.
- `DW`, 8: data width.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; high only in IDLE and not in reset.
- `req_op` in 3: 0 LOAD, 1 STORE, 2 ADD, 3 AND, 4 OR, 5 XOR, 6 SWAP, 7 reserved.
- `req_addr` in AW: target address.
- `req_wdata` in DW: store data, or RMW operand.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_data` out DW: LOAD gives read value; STORE gives written value; RMW gives the old memory value.
- `rsp_err` out 1: op 7 received.
- `mem_e` out 1: memory enable.
- `mem_we` out 1: memory write enable.
- `mem_addr` out AW: memory address.
- `mem_di` out DW: memory write data.
- `mem_do` in DW: memory read data, combinational from `mem_addr` when `mem_e`=1.

## Operation
- States: IDLE, RD, WR, RSP.
- Accept occurs when `req_valid && req_ready`. On accept, latch op, addr, wdata; `mem_addr` <= `req_addr`.
- IDLE -> RD for LOAD, RMW ops (2-6) and op 7. IDLE -> WR for STORE.
- RD: `mem_e`=1, `mem_we`=0. At cycle end, capture `mem_do` into `rdata`.
  - LOAD or op 7 -> RSP.
  - RMW -> WR.
- WR: `mem_e`=1, `mem_we`=1. `mem_di` = wdata (STORE) or f(rdata, wdata) (RMW). -> RSP.
- RMW f:
  - ADD: (rdata+wdata) mod 2^DW, carry discarded.
  - AND, OR, XOR: bitwise.
  - SWAP: wdata.
- RSP: `rsp_valid`=1. `rsp_data`, `rsp_err` stay stable until `rsp_ready`; then -> IDLE.
- Op 7 performs a LOAD, writes nothing, and sets `rsp_err`=1. All other ops give `rsp_err`=0.
- `mem_e`=`mem_we`=0 in IDLE and RSP. `mem_addr` and `mem_di` hold their last values.
- No request is accepted while a response is pending; strictly one outstanding op.

## Timing
- Reset values: state IDLE, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `mem_e`=0, `mem_we`=0, `mem_addr`=0, `mem_di`=0.
- `req_ready`=0 during any cycle `rst`=1.
- Latency from accept (cycle 0) to `rsp_valid`:
  - LOAD, STORE, op 7: cycle 2.
  - RMW: cycle 3.
- Memory write commits at the end of the WR cycle.
- Minimum issue interval with `rsp_ready` held high: 3 cycles for LOAD/STORE, 4 for RMW.
- `rsp_ready` low stalls in RSP indefinitely; memory lines stay idle.
- Reset mid-operation: return to IDLE next edge and drop the pending response. `mem_we` is gated by `!rst`, so no write occurs in a reset cycle. An RMW aborted in WR leaves memory unmodified.
- `req_valid` while not ready is ignored; requester must hold it.
- Address has no wrap logic: AW bits index the memory directly. 4'hF is legal.

## Structure
- Package `dmem_lsu_pkg`:
  - op encodings (OP_LOAD … OP_RSVD)
  - state enum (IDLE, RD, WR, RSP)
  - `AW`/`DW` defaults
- Sub-module `dmem_lsu_alu`: combinational f(op, rdata, wdata) -> DW result. Reused by the top FSM for the WR-cycle `mem_di`.

## Test plan
- Reset, then STORE addr 3 data 8'hA5, then LOAD addr 3.
  - STORE: `mem_we` pulses exactly once at cycle 1.
  - LOAD: `rsp_data`=8'hA5, `rsp_valid` at cycle 2.
- mem[5]=8'hFF, ADD addr 5 wdata 8'h02.
  - `rsp_data`=8'hFF at cycle 3; mem[5]=8'h01 (carry dropped).
- mem[7]=8'h3C, XOR 8'hFF then SWAP 8'h11.
  - XOR: response 8'h3C, memory 8'hC3.
  - SWAP: response 8'hC3, memory 8'h11.
- LOAD with `rsp_ready` held low 5 cycles.
  - `rsp_valid`/`rsp_data` stable all 5 cycles.
  - `req_ready`=0; a second `req_valid` is not accepted until 1 cycle after the handshake.
- Op 7 at addr 2 (mem[2]=8'h44).
  - `rsp_err`=1, `rsp_data`=8'h44, no `mem_we` pulse.
- ADD to addr 9 with `rst` asserted during the WR cycle.
  - mem[9] unchanged, no `rsp_valid`.
  - All outputs at reset values; `req_ready`=1 on the first cycle after `rst` deasserts.
